sseg_scan_mux: RTL and testbench

SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

---
 rtl/sseg_scan_mux.sv | 154 +++++++++++++++
 tb/tb_sseg_scan_mux.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_mux
// Description : Multiplexed seven-segment display scanner. A clock divider
//               paces a digit index across NUM_DIGITS anodes. Loads go into
//               a staging register and are promoted to the displayed (active)
//               register only at a frame wrap, so no frame ever mixes old and
//               new data. Outputs are active-low and registered.
//               Optional macro SSEG_LZ_BLANK_EN enables leading-zero
//               suppression on the active data.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_MAX    = 2200
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    ld,
  output logic                    busy,
  output logic                    frame,
  output logic [NUM_DIGITS-1:0]   disp_en,
  output logic [7:0]              segments
);

  localparam int DIV_W = $clog2(DIV_MAX + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic [DIV_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic                    tick;
  logic                    wrap;

  logic [4*NUM_DIGITS-1:0] stage_data;
  logic [NUM_DIGITS-1:0]   stage_dp;
  logic [NUM_DIGITS-1:0]   stage_blank;
  logic [4*NUM_DIGITS-1:0] act_data;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  logic [NUM_DIGITS-1:0]   dark;
  logic [3:0]              cur_nib;
  logic [7:0]              glyph;

  assign tick = (div_cnt == DIV_W'(DIV_MAX));
  assign wrap = tick && (idx == IDX_W'(NUM_DIGITS - 1));

  // Scan-rate divider and digit index; index advances once per tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= wrap ? '0 : idx + IDX_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Frame pulse marks the cycle right after the wrapping tick.
  always_ff @(posedge clk) begin
    if (rst) frame <= 1'b0;
    else     frame <= wrap;
  end

  // Staging/active registers: active updates only at a wrap so frames stay whole;
  // a load on the wrap cycle still lands in staging and keeps busy set.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_data  <= '0;
      stage_dp    <= '0;
      stage_blank <= '0;
      act_data    <= '0;
      act_dp      <= '0;
      act_blank   <= '1;
      busy        <= 1'b0;
    end else begin
      if (wrap && busy) begin
        act_data  <= stage_data;
        act_dp    <= stage_dp;
        act_blank <= stage_blank;
      end
      if (ld) begin
        stage_data  <= data;
        stage_dp    <= dp;
        stage_blank <= blank;
        busy        <= 1'b1;
      end else if (wrap) begin
        busy <= 1'b0;
      end
    end
  end

`ifdef SSEG_LZ_BLANK_EN
  // lz[i] is set when digit i and every higher digit hold zero with no dp lit.
  logic [NUM_DIGITS-1:0] lz;
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
      if (i == NUM_DIGITS - 1) begin : g_top
        assign lz[i] = (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
      end else begin : g_low
        assign lz[i] = lz[i+1] && (act_data[4*i +: 4] == 4'h0) && !act_dp[i];
      end
    end
  endgenerate
  // Digit 0 is never suppressed so a zero value still shows "0".
  assign dark = act_blank | (lz & ~NUM_DIGITS'(1));
`else
  assign dark = act_blank;
`endif

  assign cur_nib = act_data[{idx, 2'b00} +: 4];

  // Hex glyph lookup, active-low a..g in [7:1], dp bit left off.
  always_comb begin
    glyph = 8'hFF;
    case (cur_nib)
      4'h0: glyph = 8'h03;
      4'h1: glyph = 8'h9F;
      4'h2: glyph = 8'h25;
      4'h3: glyph = 8'h0D;
      4'h4: glyph = 8'h99;
      4'h5: glyph = 8'h49;
      4'h6: glyph = 8'h41;
      4'h7: glyph = 8'h1F;
      4'h8: glyph = 8'h01;
      4'h9: glyph = 8'h09;
      4'hA: glyph = 8'h11;
      4'hB: glyph = 8'hC1;
      4'hC: glyph = 8'h63;
      4'hD: glyph = 8'h85;
      4'hE: glyph = 8'h61;
      4'hF: glyph = 8'h71;
      default: glyph = 8'hFF;
    endcase
  end

  // Registered drive: one-cycle lag behind the index; dark digits suppress dp too.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_en  <= '1;
      segments <= 8'hFF;
    end else begin
      disp_en  <= ~(NUM_DIGITS'(1) << idx);
      segments <= dark[idx] ? 8'hFF : (glyph & ~{7'b0, act_dp[idx]});
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_mux
// Description : Self-checking bench for sseg_scan_mux (4 digits, divide by 4).
//               A cycle-numbered behavioural model predicts every output;
//               directed scenarios pin literal glyph values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_mux;

  localparam int ND  = 4;
  localparam int DM  = 3;
  localparam int PER = DM + 1;
  localparam int FRM = PER * ND;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic        busy;
  logic        frame;
  logic [3:0]  disp_en;
  logic [7:0]  segments;

  int checks = 0;
  int errors = 0;

  sseg_scan_mux #(.NUM_DIGITS(ND), .DIV_MAX(DM)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .ld(ld),
    .busy(busy), .frame(frame), .disp_en(disp_en), .segments(segments)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  GLYPH [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                              8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  bit          m_valid = 0;
  int          m_n = 0;          // cycles elapsed since reset release
  bit          m_busy;
  logic [15:0] m_st_d, m_act_d;
  logic [3:0]  m_st_dp, m_st_bl, m_act_dp, m_act_bl;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_en;
  logic        exp_frame, exp_busy;

  function automatic logic [7:0] model_seg(input int d);
    logic [3:0] nib;
    bit         drk;
    nib = m_act_d[4*d +: 4];
    drk = m_act_bl[d];
`ifdef SSEG_LZ_BLANK_EN
    if (d > 0 && (m_act_d >> (4*d)) == 16'h0 && (m_act_dp >> d) == 4'h0) drk = 1;
`endif
    if (drk) return 8'hFF;
    return GLYPH[nib] & (m_act_dp[d] ? 8'hFE : 8'hFF);
  endfunction

  // Outputs for the coming cycle follow from the state during the cycle just ended.
  always @(posedge clk) begin
    int  d;
    bit  wr;
    if (rst) begin
      m_valid = 1; m_n = 0; m_busy = 0;
      m_st_d = '0; m_st_dp = '0; m_st_bl = '0;
      m_act_d = '0; m_act_dp = '0; m_act_bl = 4'hF;
      exp_seg = 8'hFF; exp_en = 4'hF; exp_frame = 0; exp_busy = 0;
    end else if (m_valid) begin
      d  = (m_n / PER) % ND;
      wr = (m_n % FRM) == FRM - 1;
      exp_en    = ~(4'b0001 << d);
      exp_seg   = model_seg(d);
      exp_frame = wr;
      if (wr && m_busy) begin
        m_act_d = m_st_d; m_act_dp = m_st_dp; m_act_bl = m_st_bl;
      end
      if (ld) begin
        m_st_d = data; m_st_dp = dp; m_st_bl = blank; m_busy = 1;
      end else if (wr) begin
        m_busy = 0;
      end
      exp_busy = m_busy;
      m_n++;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("busy", busy, exp_busy);
      chk("frame", frame, exp_frame);
      chk("disp_en", disp_en, exp_en);
      chk("segments", segments, exp_seg);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_frame();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (frame) return;
    end
    checks++; errors++;
    $display("FAIL frame_timeout: got no frame expected pulse within 100 cycles");
  endtask

  task automatic check_digit(input int d, input logic [7:0] e, input string name);
    logic [3:0] tgt;
    tgt = ~(4'b0001 << d);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (disp_en == tgt) begin
        chk(name, segments, e);
        return;
      end
    end
    checks++; errors++;
    $display("FAIL %s_timeout: got disp_en %0h expected %0h", name, disp_en, tgt);
  endtask

  task automatic load(input logic [15:0] dv, input logic [3:0] dpv, input logic [3:0] bv);
    data = dv; dp = dpv; blank = bv; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    data = 16'($urandom); dp = 4'($urandom); blank = 4'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg", segments, 8'hFF);
    chk("rst_en", disp_en, 4'hF);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Dark scanning after release, frame period.
    check_digit(0, 8'hFF, "dark_d0");
    check_digit(1, 8'hFF, "dark_d1");
    wait_frame();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cnt++;
      if (frame) break;
    end
    chk("frame_period", cnt, 16);

    // Single load: busy until wrap, then F A 2 1.
    load(16'h12AF, 4'h0, 4'h0);
    chk("busy_set", busy, 1'b1);
    wait_frame();
    chk("busy_clr", busy, 1'b0);
    check_digit(0, 8'h71, "ld_d0");
    check_digit(1, 8'h11, "ld_d1");
    check_digit(2, 8'h25, "ld_d2");
    check_digit(3, 8'h9F, "ld_d3");

    // Two loads in one frame: last wins.
    wait_frame();
    load(16'h1111, 4'h0, 4'h0);
    @(negedge clk);
    load(16'h2222, 4'h0, 4'h0);
    wait_frame();
    chk("lw_busy", busy, 1'b0);
    for (int d = 0; d < 4; d++) check_digit(d, 8'h25, "lw_digit");

    // Load coincident with wrap while busy.
    wait_frame();
    load(16'h3333, 4'h0, 4'h0);
    for (int k = 0; k < 40; k++) begin
      if ((m_n % FRM) == FRM - 1) break;
      @(negedge clk);
    end
    load(16'h4444, 4'h0, 4'h0);
    chk("coin_frame", frame, 1'b1);
    chk("coin_busy", busy, 1'b1);
    for (int d = 0; d < 4; d++) check_digit(d, 8'h0D, "coin_old");
    wait_frame();
    chk("coin_busy_clr", busy, 1'b0);
    for (int d = 0; d < 4; d++) check_digit(d, 8'h99, "coin_new");

    // Blank and decimal point.
    wait_frame();
    load(16'h8888, 4'b0001, 4'b0100);
    wait_frame();
    check_digit(0, 8'h00, "bd_d0");
    check_digit(1, 8'h01, "bd_d1");
    check_digit(2, 8'hFF, "bd_d2");
    check_digit(3, 8'h01, "bd_d3");

    // Leading zeros.
    wait_frame();
    load(16'h0050, 4'h0, 4'h0);
    wait_frame();
    check_digit(0, 8'h03, "lz_d0");
    check_digit(1, 8'h49, "lz_d1");
`ifdef SSEG_LZ_BLANK_EN
    check_digit(2, 8'hFF, "lz_d2");
    check_digit(3, 8'hFF, "lz_d3");
`else
    check_digit(2, 8'h03, "lz_d2");
    check_digit(3, 8'h03, "lz_d3");
`endif

    // Reset wins over a simultaneous load; display stays dark afterwards.
    @(negedge clk);
    rst = 1'b1; ld = 1'b1; data = 16'h5678;
    @(negedge clk);
    rst = 1'b0; ld = 1'b0;
    chk("rstld_busy", busy, 1'b0);
    chk("rstld_seg", segments, 8'hFF);
    wait_frame();
    check_digit(0, 8'hFF, "rst_dark_d0");

    // Randomized traffic including mid-frame resets and unloaded input churn.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      data  = 16'($urandom);
      dp    = 4'($urandom);
      blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      ld    = ($urandom_range(0, 9) == 0);
      rst   = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; ld = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
